seq_alu: RTL and testbench

Parametrised, handshaked successor to the team's 2-bit-opcode combinational ALU. Registers one operation per transaction and adds XOR, signed set-less-than and an iterative unsigned multiply. Produces a full NZCV flag set and holds the result under output backpressure. Sits between an operand source and a result sink, both using valid/ready.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/shift_add_mul.sv | 52 +++++
 rtl/seq_alu.sv | 163 ++++++++++++++++
 tb/tb_seq_alu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
//   op_e    : 3-bit opcode encoding presented on the op port
//   state_e : control FSM states
//   flags_t : registered NZCV flag bundle (z, n, c, v)
package alu_pkg;

    localparam int unsigned OpWidth = 3;

    typedef enum logic [OpWidth-1:0] {
        OpAnd  = 3'b000,
        OpOr   = 3'b001,
        OpAdd  = 3'b010,
        OpSub  = 3'b011,
        OpXor  = 3'b100,
        OpSlt  = 3'b101,
        OpMul  = 3'b110,
        OpRsvd = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDone = 2'b10
    } state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin WIDTH iterations
//   a, b       : multiplicand, multiplier (unsigned)
//   done       : high during the final iteration; product is valid in that cycle
//   product    : 2*WIDTH-bit product including the current iteration
module shift_add_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] acc_next;

    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    // Exposing acc_next lets the caller capture the result on the last iteration edge.
    assign product  = acc_next;
    assign done     = (cnt_q == CntW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CntW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CntW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: AND/OR/ADD/SUB/XOR/SLT in one cycle, MUL iteratively.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, op            : operands and 3-bit opcode
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   result              : registered WIDTH-bit result
//   flag_z/n/c/v        : registered zero, negative, carry/borrow, overflow flags
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int unsigned Msb = WIDTH - 1;

    state_e state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t flags_q, flags_d;
    logic load_alu, load_mul, mul_start;

    op_e op_in;
    assign op_in = op_e'(op);

    // Single-cycle datapath
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op_in)
            OpAnd: alu_res = a & b;
            OpOr:  alu_res = a | b;
            OpXor: alu_res = a ^ b;
            OpAdd: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[Msb] == b[Msb]) & (sum[Msb] != a[Msb]);
            end
            OpSub: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH]; // borrow: a < b unsigned
                alu_v   = (a[Msb] != b[Msb]) & (diff[Msb] != a[Msb]);
            end
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = '0; // OpMul handled by the multiplier, OpRsvd yields zero
        endcase
    end

    // Iterative multiplier
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_lo, mul_hi;

    assign mul_lo = mul_prod[WIDTH-1:0];
    assign mul_hi = mul_prod[2*WIDTH-1:WIDTH];

    shift_add_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .product(mul_prod)
    );

    // Control FSM
    always_comb begin
        state_d   = state_q;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (op_in == OpMul) begin
                        mul_start = 1'b1;
                        state_d   = StMul;
                    end else begin
                        load_alu = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StMul: begin
                if (mul_done) begin
                    load_mul = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register next-state
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        if (load_mul) begin
            result_d  = mul_lo;
            flags_d.z = (mul_lo == '0);
            flags_d.n = mul_lo[Msb];
            flags_d.c = |mul_hi;
            flags_d.v = |mul_hi;
        end else if (load_alu) begin
            result_d  = alu_res;
            flags_d.z = (alu_res == '0);
            flags_d.n = alu_res[Msb];
            flags_d.c = alu_c;
            flags_d.v = alu_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign flag_z    = flags_q.z;
    assign flag_n    = flags_q.n;
    assign flag_c    = flags_q.c;
    assign flag_v    = flags_q.v;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed cases plus randomized ops
// compared against an integer-arithmetic reference model.
module tb_seq_alu;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] result;
    logic         flag_z, flag_n, flag_c, flag_v;
    logic [3:0]   flags_obs;

    int checks = 0;
    int errors = 0;

    assign flags_obs = {flag_z, flag_n, flag_c, flag_v};

    always #5 clk = ~clk;

    seq_alu #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .flag_c   (flag_c),
        .flag_v   (flag_v)
    );

    // Reference model: returns {result, z, n, c, v} from plain integer arithmetic.
    function automatic logic [W+3:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        longint full, half, ux, uy, sx, sy, r, sr;
        logic c, v;
        logic [W-1:0] res;
        full = longint'(1) << W;
        half = full / 2;
        ux = longint'(x);
        uy = longint'(y);
        sx = (ux >= half) ? ux - full : ux;
        sy = (uy >= half) ? uy - full : uy;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (o)
            3'd0: r = ux & uy;
            3'd1: r = ux | uy;
            3'd2: begin
                r = ux + uy;
                c = (r >= full);
                sr = sx + sy;
                v = (sr >= half) || (sr < -half);
                r = r % full;
            end
            3'd3: begin
                c = (ux < uy);
                r = ux - uy;
                if (r < 0) r = r + full;
                sr = sx - sy;
                v = (sr >= half) || (sr < -half);
            end
            3'd4: r = ux ^ uy;
            3'd5: r = (sx < sy) ? 1 : 0;
            3'd6: begin
                r = ux * uy;
                c = (r >= full);
                v = c;
                r = r % full;
            end
            default: r = 0;
        endcase
        res = r[W-1:0];
        return {res, (r == 0), (r >= half), c, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold = cycles of out_ready=0 after out_valid rises.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int hold, output logic [W-1:0] r, output logic [3:0] f);
        logic [W+3:0] exp;
        int n;
        int lat;
        exp = model(o, x, y);
        lat = (o == 3'b110) ? W : 0;
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 4 * W) begin
            check("busy_not_ready", in_ready, 0);
            tick();
            n++;
        end
        check("latency", n, lat);
        check("result", result, exp[W+3:4]);
        check("flags", flags_obs, exp[3:0]);
        r = result;
        f = flags_obs;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_result", result, exp[W+3:4]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after", {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        logic [W-1:0] r;
        logic [3:0]   f;

        // Reset values
        #2;
        check("rst_outputs", {in_ready, out_valid, result, flags_obs}, {2'b10, 8'h00, 4'h0});
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ADD overflow into sign bit, then backpressure with new operands presented
        in_valid = 1'b1;
        op = 3'b010;
        a = 8'h7F;
        b = 8'h01;
        tick();
        check("add_valid", out_valid, 1);
        check("add_result", result, 8'h80);
        check("add_flags", flags_obs, 4'b0101);
        op = 3'b001;
        a = 8'h11;
        b = 8'h22;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_result", result, 8'h80);
            check("bp_flags", flags_obs, 4'b0101);
            check("bp_handshake", {in_ready, out_valid}, 2'b01);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", {in_ready, out_valid}, 2'b10);
        tick();
        in_valid = 1'b0;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_result", result, 8'h33);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Directed cases from the test plan
        do_op(3'b011, 8'h00, 8'h01, 0, r, f);
        check("sub_borrow", {r, f}, {8'hFF, 4'b0110});
        do_op(3'b011, 8'h80, 8'h01, 1, r, f);
        check("sub_ovf", {r, f}, {8'h7F, 4'b0001});
        do_op(3'b110, 8'h0D, 8'h0B, 0, r, f);
        check("mul_0d_0b", {r, f}, {8'h8F, 4'b0100});
        do_op(3'b110, 8'h10, 8'h10, 2, r, f);
        check("mul_hi", {r, f}, {8'h00, 4'b1011});
        do_op(3'b101, 8'h80, 8'h01, 0, r, f);
        check("slt_neg", {r, f}, {8'h01, 4'b0000});
        do_op(3'b111, 8'hA5, 8'h5A, 0, r, f);
        check("rsvd", {r, f}, {8'h00, 4'b1000});

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 3)), r, f);
        end

        // Asynchronous reset in the middle of a MUL
        do_op(3'b010, 8'h40, 8'h05, 0, r, f);
        in_valid = 1'b1;
        op = 3'b110;
        a = 8'h0D;
        b = 8'h0B;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {in_ready, out_valid, result, flags_obs}, {2'b10, 8'h00, 4'h0});
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("mul_discarded", {in_ready, out_valid}, 2'b10);
        end
        do_op(3'b010, 8'h02, 8'h03, 0, r, f);
        check("add_after_rst", {r, f}, {8'h05, 4'b0000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
